approx_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `signed_int_mul` instance (8b×8b signed → 16b, `Conf_Bit_Mask` 6b) between N_REQ requesters. Each requester owns a programmable approximation mask. The block issues one multiply per cycle through a 2-stage registered pipeline and returns the result tagged with the requester ID over a valid/ready response port. It sits between the accelerator's operand producers and the approximate multiplier datapath.

---
 rtl/approx_mul_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_approx_mul_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_arbiter.sv
// Round-robin arbiter sharing one approximate signed 8x8 multiplier between N_REQ
// requesters, with per-requester masks and a 2-stage valid/ready result pipeline.
`timescale 1ns/1ps

module signed_int_mul (
  input  logic signed [7:0]  A,
  input  logic signed [7:0]  B,
  input  logic        [5:0]  Conf_Bit_Mask,
  output logic signed [15:0] R
);
  logic signed [15:0] prod_s;

  assign prod_s = A * B;
  // Each set mask bit forces the matching low-order product bit to zero.
  assign R = prod_s & ~{10'b0, Conf_Bit_Mask};
endmodule

module approx_mul_arbiter #(
  parameter int         N_REQ    = 4,
  parameter int         ID_W     = 2,
  parameter logic [5:0] MASK_RST = 6'b000011
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  input  logic                 cfg_we,
  input  logic [ID_W-1:0]      cfg_id,
  input  logic [5:0]           cfg_mask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_result,
  output logic [15:0]          op_count
);
  logic              run_q;
  logic [ID_W-1:0]   last_q, last_d;
  logic [5:0]        mask_q [N_REQ];
  logic [5:0]        mask_d [N_REQ];
  logic              s1_valid_q, s1_valid_d;
  logic [7:0]        s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [5:0]        s1_mask_q, s1_mask_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [15:0]       rsp_result_q, rsp_result_d;
  logic [15:0]       op_count_q, op_count_d;

  logic              s2_adv_s, s1_adv_s, accept_s, gnt_found_s;
  logic [ID_W-1:0]   gnt_id_s;
  logic [7:0]        sel_a_s, sel_b_s;
  logic [5:0]        sel_mask_s;
  logic [15:0]       mul_r_s;

  assign s2_adv_s = !rsp_valid_q || rsp_ready;
  assign s1_adv_s = !s1_valid_q || s2_adv_s;
  // run_q keeps grants off while reset is asserted and for the first edge after.
  assign accept_s = run_q && s1_adv_s && gnt_found_s;

  signed_int_mul u_mul (
    .A             (s1_a_q),
    .B             (s1_b_q),
    .Conf_Bit_Mask (s1_mask_q),
    .R             (mul_r_s)
  );

  // Round-robin pick: scan offsets last+1 .. last+N_REQ, first valid requester wins.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_id_s    = '0;
    sel_a_s     = 8'd0;
    sel_b_s     = 8'd0;
    sel_mask_s  = 6'd0;
    for (int off = 1; off <= N_REQ; off++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!gnt_found_s && req_valid[i] && ((int'(last_q) + off) % N_REQ == i)) begin
          gnt_found_s = 1'b1;
          gnt_id_s    = ID_W'(i);
          sel_a_s     = req_a[8*i +: 8];
          sel_b_s     = req_b[8*i +: 8];
          sel_mask_s  = mask_q[i];
        end else begin
          gnt_found_s = gnt_found_s;
        end
      end
    end
  end

  // One-hot ready for the granted requester when stage 1 can take it.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept_s && (int'(gnt_id_s) == i);
    end
  end

  // Next-state for mask bank, stage 1, stage 2 and the accept counter.
  always_comb begin
    last_d       = last_q;
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_mask_d    = s1_mask_q;
    s1_id_d      = s1_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    op_count_d   = op_count_q;
    for (int i = 0; i < N_REQ; i++) begin
      // Out-of-range ids match no entry, so those writes are dropped.
      if (cfg_we && (int'(cfg_id) == i)) begin
        mask_d[i] = cfg_mask;
      end else begin
        mask_d[i] = mask_q[i];
      end
    end

    if (s2_adv_s) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_result_d = mul_r_s;
        rsp_id_d     = s1_id_q;
      end else begin
        rsp_result_d = rsp_result_q;
      end
    end else begin
      rsp_valid_d = rsp_valid_q;
    end

    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_a_d     = sel_a_s;
      s1_b_d     = sel_b_s;
      s1_mask_d  = sel_mask_s;
      s1_id_d    = gnt_id_s;
      last_d     = gnt_id_s;
      op_count_d = op_count_q + 16'd1;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      last_q       <= ID_W'(N_REQ - 1);
      for (int i = 0; i < N_REQ; i++) mask_q[i] <= MASK_RST;
      s1_valid_q   <= 1'b0;
      s1_a_q       <= 8'd0;
      s1_b_q       <= 8'd0;
      s1_mask_q    <= 6'd0;
      s1_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= 16'd0;
      op_count_q   <= 16'd0;
    end else begin
      run_q        <= 1'b1;
      last_q       <= last_d;
      for (int i = 0; i < N_REQ; i++) mask_q[i] <= mask_d[i];
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_mask_q    <= s1_mask_d;
      s1_id_q      <= s1_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign op_count   = op_count_q;
endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Directed bench for approx_mul_arbiter: reset, grant order, pipeline flow control,
// mask configuration races and a full 8x8 operand sweep.
`timescale 1ns/1ps

module tb_approx_mul_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        cfg_we;
  logic [2:0]  cfg_id;
  logic [5:0]  cfg_mask;
  logic        rsp_valid, rsp_ready;
  logic [2:0]  rsp_id;
  logic [15:0] rsp_result, op_count;
  int n_vec = 0;
  int n_err = 0;

  approx_mul_arbiter #(.N_REQ(4), .ID_W(3), .MASK_RST(6'b000011)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_mask(cfg_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Reference: exact signed product with masked low bits cleared.
  function automatic logic [15:0] ref_mul(input logic signed [7:0] a, input logic signed [7:0] b,
                                          input logic [5:0] m);
    logic signed [15:0] p;
    p = a * b;
    return p & ~{10'b0, m};
  endfunction

  // Hand-computed results for the round-robin operand set with mask 6'b000011.
  function automatic logic [15:0] exp_rr(input int i);
    case (i)
      0: return 16'h003C;  //   7 *  9 =  63
      1: return 16'hFF9C;  //  -9 * 11 = -99
      2: return 16'hFFA4;  //  15 * -6 = -90
      3: return 16'h0104;  // -20 * -13 = 260
      default: return 16'h0000;
    endcase
  endfunction

  task automatic set_rr_operands();
    req_a = {8'hEC, 8'h0F, 8'hF7, 8'h07};
    req_b = {8'hF3, 8'hFA, 8'h0B, 8'h09};
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 8 && !ok; c++) begin
      if (req_ready != 4'b0000) ok = 1'b1;
      else begin tick(); settle(); end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 4'b0000; cfg_we = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1; cfg_we = 1'b0;
    cfg_id = 3'd0; cfg_mask = 6'd0; req_a = 32'd0; req_b = 32'd0;
    tick(); tick(); settle();
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_vec++; if (op_count !== 16'd0) begin n_err++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    rst_n = 1'b1;
    settle();
    wait_grant(ok);
    n_vec++; if (!ok || req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    req_valid = 4'b0000;
    settle();
  endtask

  task automatic test_single();
    req_a = 32'd0; req_b = 32'd0;
    req_a[23:16] = 8'h80; req_b[23:16] = 8'h7F;
    req_valid = 4'b0100; rsp_ready = 1'b1;
    settle();
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
    tick(); req_valid = 4'b0000; settle();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early got=%b exp=0", rsp_valid); end
    tick(); settle();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd2 || rsp_result !== 16'hC080)
      begin n_err++; $display("FAIL single_rsp got v=%b id=%0d r=%h exp v=1 id=2 r=c080", rsp_valid, rsp_id, rsp_result); end
    n_vec++; if (op_count !== 16'd1) begin n_err++; $display("FAIL single_count got=%0d exp=1", op_count); end
    tick(); settle();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    set_rr_operands();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    settle();
    wait_grant(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rr_start got=no_grant exp=grant"); end
    for (int k = 0; k < 10; k++) begin
      if (k == 8) begin req_valid = 4'b0000; settle(); end
      if (k < 8) begin
        n_vec++; if (req_ready !== (4'b0001 << (k % 4)))
          begin n_err++; $display("FAIL rr_grant_%0d got=%b exp=%b", k, req_ready, 4'b0001 << (k % 4)); end
      end
      if (k < 2) begin
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_idle_%0d got=%b exp=0", k, rsp_valid); end
      end else begin
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'((k - 2) % 4) || rsp_result !== exp_rr((k - 2) % 4))
          begin n_err++; $display("FAIL rr_rsp_%0d got v=%b id=%0d r=%h exp v=1 id=%0d r=%h",
                                  k, rsp_valid, rsp_id, rsp_result, (k - 2) % 4, exp_rr((k - 2) % 4)); end
      end
      tick(); settle();
    end
    n_vec++; if (op_count !== 16'd8) begin n_err++; $display("FAIL rr_count got=%0d exp=8", op_count); end
  endtask

  task automatic test_backpressure();
    int cnt = 0;
    req_valid = 4'b0011; rsp_ready = 1'b0;
    settle();
    for (int c = 0; c < 6; c++) begin
      if (req_ready != 4'b0000) cnt++;
      tick(); settle();
    end
    n_vec++; if (cnt != 2) begin n_err++; $display("FAIL bp_accepts got=%0d exp=2", cnt); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready got=%b exp=0000", req_ready); end
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_result !== 16'h003C)
      begin n_err++; $display("FAIL bp_hold got v=%b id=%0d r=%h exp v=1 id=0 r=003c", rsp_valid, rsp_id, rsp_result); end
    n_vec++; if (op_count !== 16'd10) begin n_err++; $display("FAIL bp_count got=%0d exp=10", op_count); end
    rsp_ready = 1'b1; settle();
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_release_grant got=%b exp=0001", req_ready); end
    tick(); rsp_ready = 1'b0; settle();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_result !== 16'hFF9C || req_ready !== 4'b0000)
      begin n_err++; $display("FAIL bp_one_drain got v=%b id=%0d r=%h rdy=%b exp v=1 id=1 r=ff9c rdy=0000",
                              rsp_valid, rsp_id, rsp_result, req_ready); end
    n_vec++; if (op_count !== 16'd11) begin n_err++; $display("FAIL bp_count2 got=%0d exp=11", op_count); end
    req_valid = 4'b0000; rsp_ready = 1'b1;
    tick(); settle();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_result !== 16'h003C)
      begin n_err++; $display("FAIL bp_tail got v=%b id=%0d r=%h exp v=1 id=0 r=003c", rsp_valid, rsp_id, rsp_result); end
    tick(); settle();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_config_race();
    req_valid = 4'b0010; cfg_we = 1'b1; cfg_id = 3'd1; cfg_mask = 6'b111111;
    settle();
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL cfg_grant got=%b exp=0010", req_ready); end
    tick(); cfg_we = 1'b0; settle();
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL cfg_regrant got=%b exp=0010", req_ready); end
    tick(); req_valid = 4'b0000; settle();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_result !== 16'hFF9C)
      begin n_err++; $display("FAIL cfg_old_mask got v=%b id=%0d r=%h exp v=1 id=1 r=ff9c", rsp_valid, rsp_id, rsp_result); end
    tick(); settle();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_result !== 16'hFF80)
      begin n_err++; $display("FAIL cfg_new_mask got v=%b id=%0d r=%h exp v=1 id=1 r=ff80", rsp_valid, rsp_id, rsp_result); end
    cfg_we = 1'b1; cfg_id = 3'd5; cfg_mask = 6'b000000;
    tick(); cfg_we = 1'b0; req_valid = 4'b0011; settle();
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL cfg_oor_grant0 got=%b exp=0001", req_ready); end
    tick(); settle();
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL cfg_oor_grant1 got=%b exp=0010", req_ready); end
    tick(); req_valid = 4'b0000; settle();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_result !== 16'h003C)
      begin n_err++; $display("FAIL cfg_oor_req0 got v=%b id=%0d r=%h exp v=1 id=0 r=003c", rsp_valid, rsp_id, rsp_result); end
    tick(); settle();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_result !== 16'hFF80)
      begin n_err++; $display("FAIL cfg_oor_req1 got v=%b id=%0d r=%h exp v=1 id=1 r=ff80", rsp_valid, rsp_id, rsp_result); end
    n_vec++; if (op_count !== 16'd15) begin n_err++; $display("FAIL cfg_count got=%0d exp=15", op_count); end
    tick(); settle();
  endtask

  task automatic test_reset_sweep();
    bit ok;
    logic [15:0] v;
    logic [15:0] e;
    rsp_ready = 1'b0; req_valid = 4'b0011;
    tick(); tick(); tick(); settle();
    n_vec++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000)
      begin n_err++; $display("FAIL mid_full got v=%b rdy=%b exp v=1 rdy=0000", rsp_valid, req_ready); end
    rst_n = 1'b0; #1;
    n_vec++; if (rsp_valid !== 1'b0 || op_count !== 16'd0 || req_ready !== 4'b0000)
      begin n_err++; $display("FAIL mid_reset got v=%b cnt=%0d rdy=%b exp v=0 cnt=0 rdy=0000", rsp_valid, op_count, req_ready); end
    tick(); settle();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_hold got=%b exp=0", rsp_valid); end
    req_valid = 4'b0001; rsp_ready = 1'b1; req_a = 32'd0; req_b = 32'd0;
    rst_n = 1'b1; settle();
    wait_grant(ok);
    n_vec++; if (!ok || rsp_valid !== 1'b0 || op_count !== 16'd0)
      begin n_err++; $display("FAIL sweep_start got ok=%b v=%b cnt=%0d exp ok=1 v=0 cnt=0", ok, rsp_valid, op_count); end
    for (int n = 0; n < 65538; n++) begin
      if (n < 65536) begin
        v = 16'(n);
        req_a[7:0] = v[15:8]; req_b[7:0] = v[7:0];
        settle();
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL sweep_grant_%0d got=%b exp=0001", n, req_ready); end
      end else begin
        req_valid = 4'b0000; settle();
      end
      if (n >= 2) begin
        v = 16'(n - 2);
        e = ref_mul(v[15:8], v[7:0], 6'b000011);
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_result !== e)
          begin n_err++; $display("FAIL sweep_rsp_%0d got v=%b id=%0d r=%h exp v=1 id=0 r=%h", n - 2, rsp_valid, rsp_id, rsp_result, e); end
      end
      tick();
    end
    settle();
    n_vec++; if (op_count !== 16'd0) begin n_err++; $display("FAIL sweep_wrap got=%0d exp=0", op_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_config_race();
    test_reset_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
